// File: rtl/sprite_fetch_arbiter.sv
// Sprite graphics RAM arbiter: per-line 16-slot two-word fetch plus posted CPU writes.
// Optional line-wrap abort with sticky overrun flag under `SPRITE_FETCH_OVERRUN_EN.
module sprite_fetch_arbiter #(
  parameter int unsigned NUM_SPRITES = 16,
  parameter int unsigned FETCH_START = 704,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [11:0]       pix_col,
  output logic [4:0]        sprite_index,
  input  logic [ADDR_W-1:0] sprite_addr,
  output logic [1:0]        sprite_dvalid,
  output logic [DATA_W-1:0] sprite_data,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              line_done,
  output logic              overrun
);

  localparam int unsigned IDX_W    = 5;
  localparam logic [IDX_W-1:0] IDX_IDLE = IDX_W'(NUM_SPRITES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SPRITES - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RD0, S_RD1, S_NEXT} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [1:0]          dvalid_q, dvalid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic                hold_v_q, hold_v_d;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic                line_done_q, line_done_d;
`ifdef SPRITE_FETCH_OVERRUN_EN
  logic                overrun_q, overrun_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      idx_q       <= IDX_IDLE;
      dvalid_q    <= '0;
      data_q      <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      hold_v_q    <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
      line_done_q <= 1'b0;
`ifdef SPRITE_FETCH_OVERRUN_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      idx_q       <= idx_d;
      dvalid_q    <= dvalid_d;
      data_q      <= data_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      hold_v_q    <= hold_v_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      line_done_q <= line_done_d;
`ifdef SPRITE_FETCH_OVERRUN_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    idx_d       = idx_q;
    dvalid_d    = 2'b00;
    data_d      = data_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    hold_v_d    = hold_v_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    line_done_d = 1'b0;
`ifdef SPRITE_FETCH_OVERRUN_EN
    overrun_d   = overrun_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pix_col == 12'(FETCH_START)) begin
          state_d = S_SETUP;
          idx_d   = '0;
        end
      end
      S_SETUP: begin
        a_d     = sprite_addr;
        state_d = S_RD0;
      end
      S_RD0: state_d = S_RD1;
      S_RD1: begin
        state_d  = S_NEXT;
        dvalid_d = 2'b01;
        data_d   = ram_rdata;
      end
      S_NEXT: begin
        dvalid_d = 2'b10;
        data_d   = ram_rdata;
        if (idx_q < IDX_LAST) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SETUP;
        end else begin
          idx_d       = IDX_IDLE;
          state_d     = S_IDLE;
          line_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SPRITE_FETCH_OVERRUN_EN
    // Line wrap mid-fetch: drop the rest of the line and anything in flight.
    if (state_q != S_IDLE && pix_col == 12'd0) begin
      state_d     = S_IDLE;
      idx_d       = IDX_IDLE;
      dvalid_d    = 2'b00;
      line_done_d = 1'b0;
      overrun_d   = 1'b1;
    end
`endif

    // Port ownership follows the state the registered port outputs will appear in.
    if (state_d == S_RD0) begin
      ram_en_d   = 1'b1;
      ram_addr_d = a_d;
    end else if (state_d == S_RD1) begin
      ram_en_d   = 1'b1;
      ram_addr_d = a_q + ADDR_W'(1);
    end else if (hold_v_q) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = hold_addr_q;
      ram_wdata_d = hold_data_q;
      hold_v_d    = 1'b0;
    end

    if (cpu_wr && !hold_v_q) begin
      hold_v_d    = 1'b1;
      hold_addr_d = cpu_addr;
      hold_data_d = cpu_wdata;
    end
  end

  assign sprite_index  = idx_q;
  assign sprite_dvalid = dvalid_q;
  assign sprite_data   = data_q;
  assign cpu_busy      = hold_v_q;
  assign ram_en        = ram_en_q;
  assign ram_we        = ram_we_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;
  assign line_done     = line_done_q;
`ifdef SPRITE_FETCH_OVERRUN_EN
  assign overrun       = overrun_q;
`else
  assign overrun       = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Bench for sprite_fetch_arbiter: RAM and sprite_man models, per-cycle timing model
// derived from slot arithmetic, random CPU write traffic against a shadow memory.
module tb_sprite_fetch_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned FS = 704;
`ifdef SPRITE_FETCH_OVERRUN_EN
  localparam bit OV_EN = 1'b1;
`else
  localparam bit OV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   pix_col;
  logic [4:0]    sprite_index;
  logic [AW-1:0] sprite_addr;
  logic [1:0]    sprite_dvalid;
  logic [DW-1:0] sprite_data;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_busy;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          line_done;
  logic          overrun;

  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] sh  [0:4095];
  int n_pass = 0;
  int n_fail = 0;
  int n_tot  = 0;
  logic ov_exp = 1'b0;

  always #20 clk = ~clk;

  sprite_fetch_arbiter dut (
    .clk(clk), .rst(rst), .pix_col(pix_col),
    .sprite_index(sprite_index), .sprite_addr(sprite_addr),
    .sprite_dvalid(sprite_dvalid), .sprite_data(sprite_data),
    .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_busy(cpu_busy),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .line_done(line_done), .overrun(overrun)
  );

  // sprite_man stand-in: slot n's graphics start at word 2n
  assign sprite_addr = AW'({sprite_index, 1'b0});

  // Synchronous single-port RAM, preloaded with 0xC0DE0000 + k
  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = 32'hC0DE0000 + 32'(k);
    ram_rdata = '0;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else        ram_rdata     <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit blocked(input int j, input int lim);
    return j >= 1 && j <= 64 && j <= lim && (((j - 1) % 4 == 1) || ((j - 1) % 4 == 2));
  endfunction

  task automatic chk_quiet(input string tag);
    chk(tag, {sprite_index, sprite_dvalid, line_done, ram_en, ram_we, cpu_busy},
             {5'd16, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
  endtask

  // One scan line: fetch triggered at j=0, optional CPU write at t_wr (plus a
  // dropped follow-up when dbl), optional pix_col=0 wrap driven in cycle abort_j.
  task automatic run_line(input int t_wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input bit dbl, input int abort_j);
    int lim, vis, pc, k;
    bit ab, fetch, dv0, dv1, rd0, rd1, wr;
    logic [AW-1:0] wa2;
    logic [DW-1:0] wd2;
    ab  = (abort_j > 0) && OV_EN;
    lim = ab ? abort_j : 1000;
    vis = -1;
    if (t_wr >= 0) begin
      vis = t_wr + 2;
      while (blocked(vis, lim)) vis++;
    end
    wa2 = wa + AW'(1);
    wd2 = ~wd;
    pc = FS;
    pix_col = 12'(pc);
    cpu_wr = (t_wr == 0);
    cpu_addr = wa;
    cpu_wdata = wd;
    for (int j = 1; j <= 72; j++) begin
      step();
      cpu_wr = 1'b0;
      if (ab && j > abort_j) ov_exp = 1'b1;
      fetch = (j <= lim);
      dv0 = fetch && j >= 4 && j <= 64 && (j % 4 == 0);
      dv1 = fetch && j >= 5 && j <= 65 && ((j - 5) % 4 == 0);
      rd0 = fetch && j >= 2 && j <= 62 && ((j - 2) % 4 == 0);
      rd1 = fetch && j >= 3 && j <= 63 && ((j - 3) % 4 == 0);
      wr  = (j == vis);
      chk("dvalid", 64'(sprite_dvalid), 64'({dv1, dv0}));
      if (dv0) begin
        k = (j - 4) / 4;
        chk("word0", 64'(sprite_data), 64'(sh[2*k]));
      end
      if (dv1) begin
        k = (j - 5) / 4;
        chk("word1", 64'(sprite_data), 64'(sh[2*k+1]));
      end
      chk("line_done", 64'(line_done), 64'(fetch && j == 65));
      chk("index", 64'(sprite_index), (fetch && j <= 64) ? 64'((j - 1) / 4) : 64'd16);
      chk("ram_en_we", 64'({ram_en, ram_we}), 64'({rd0 || rd1 || wr, wr}));
      if (rd0) chk("rd0_addr", 64'(ram_addr), 64'(2 * ((j - 2) / 4)));
      if (rd1) chk("rd1_addr", 64'(ram_addr), 64'(2 * ((j - 3) / 4) + 1));
      if (wr) begin
        chk("wr_addr", 64'(ram_addr), 64'(wa));
        chk("wr_data", 64'(ram_wdata), 64'(wd));
        sh[wa] = wd;
      end
      chk("busy", 64'(cpu_busy), 64'(t_wr >= 0 && j > t_wr && j < vis));
      chk("overrun", 64'(overrun), 64'(ov_exp));
      pc = (j == abort_j) ? 0 : pc + 1;
      pix_col = 12'(pc);
      if (j == t_wr) begin
        cpu_wr = 1'b1; cpu_addr = wa; cpu_wdata = wd;
      end else if (dbl && t_wr >= 0 && j == t_wr + 1) begin
        cpu_wr = 1'b1; cpu_addr = wa2; cpu_wdata = wd2;
      end
    end
    cpu_wr = 1'b0;
    if (dbl && t_wr >= 0) chk("dropped_wr", 64'(mem[wa2]), 64'(sh[wa2]));
  endtask

  // Directed IDLE write: busy for one cycle, port write in the following cycle.
  task automatic idle_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
    step();
    cpu_wr = 1'b0;
    chk("iw_busy", 64'({cpu_busy, ram_en}), 64'({1'b1, 1'b0}));
    step();
    chk("iw_port", {ram_en, ram_we, cpu_busy, ram_addr, ram_wdata},
                   {1'b1, 1'b1, 1'b0, a, d});
    sh[a] = d;
    step();
    chk("iw_after", 64'({ram_en, cpu_busy}), 64'd0);
    chk("iw_mem", 64'(mem[a]), 64'(d));
  endtask

  initial begin
    logic [AW-1:0] ra;
    for (int k = 0; k < 4096; k++) sh[k] = 32'hC0DE0000 + 32'(k);
    rst = 1'b1; pix_col = '0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    #5;
    chk("rst_ctl", {sprite_index, sprite_dvalid, line_done, cpu_busy, ram_en, ram_we, overrun},
                   {5'd16, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    chk("rst_bus", {sprite_data, ram_addr}, '0);
    chk("rst_wdata", 64'(ram_wdata), 64'd0);
    step(); step();
    rst = 1'b0;
    // Ramp through the visible line: no fetch and no port activity before FETCH_START
    for (int c = 0; c < FS; c++) begin
      pix_col = 12'(c);
      step();
      chk_quiet("pre_fetch");
    end

    run_line(-1, '0, '0, 1'b0, 0);
    idle_write(12'h100, 32'hDEADBEEF);
    run_line(2, 12'h100, 32'hDEADBEEF, 1'b1, 0);

    for (int r = 0; r < 6; r++) begin
      for (int w = 0; w < 4; w++) begin
        ra = AW'($urandom_range(31, 0));
        idle_write(ra, $urandom);
      end
      run_line(int'($urandom_range(66, 0)), AW'($urandom_range(4094, 64)), $urandom,
               1'($urandom_range(1, 0)), 0);
    end

    // Line wrap at slot 5's SETUP cycle
    run_line(-1, '0, '0, 1'b0, 21);
    step();
    chk("ov_hold", 64'(overrun), 64'(ov_exp));

    // Reset mid-fetch with a held CPU write pending
    pix_col = 12'(FS);
    for (int j = 1; j <= 10; j++) begin
      step();
      cpu_wr = 1'b0;
      pix_col = 12'(FS + j);
      if (j == 9) begin
        cpu_wr = 1'b1; cpu_addr = 12'h200; cpu_wdata = 32'h12345678;
      end
    end
    chk("mid_busy", 64'(cpu_busy), 64'd1);
    rst = 1'b1;
    #2;
    ov_exp = 1'b0;
    chk("mid_rst", {sprite_index, sprite_dvalid, line_done, cpu_busy, ram_en, overrun},
                   {5'd16, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    step();
    rst = 1'b0;
    for (int j = 0; j < 20; j++) begin
      pix_col = 12'(FS + 20 + j);
      step();
      chk_quiet("post_rst");
    end
    chk("held_discarded", 64'(mem[12'h200]), 64'(sh[12'h200]));

    run_line(-1, '0, '0, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
